// File: rtl/qdrv_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// qdrv_mem_loader_pkg
//
// Purpose:
//   Shared definitions for the framed burst loader that fills the per-core
//   element memories (cmd, env, freq, ...) of the dsp core array.
//
// Contents:
//   - Header word field positions and widths (BASE, MEM_SEL, CORE_SEL).
//   - Length word field position and width.
//   - Loader FSM state enum.
//   - mem_aw(): extracts the 5-bit address width of one memory type from the
//     packed MEM_AW_VEC parameter (mem0 at the LSBs).
// -----------------------------------------------------------------------------
package qdrv_mem_loader_pkg;

  // Header word layout: [15:0] base, [18:16] mem_sel, [22:19] core_sel.
  // Bits [31:23] are reserved and ignored by the loader.
  localparam int HDR_BASE_LSB = 0;
  localparam int HDR_BASE_W   = 16;
  localparam int HDR_MEM_LSB  = 16;
  localparam int HDR_MEM_W    = 3;
  localparam int HDR_CORE_LSB = 19;
  localparam int HDR_CORE_W   = 4;

  // Length word layout: [15:0] number of data words that follow.
  localparam int LEN_LSB = 0;
  localparam int LEN_W   = 16;

  // Each memory type gets a 5-bit address-width field; up to 8 types.
  localparam int AW_FIELD_W = 5;
  localparam int MAX_MEMS   = 8;
  localparam int AW_VEC_W   = AW_FIELD_W * MAX_MEMS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a header word
    ST_LEN  = 2'd1,  // waiting for the length word
    ST_DATA = 2'd2,  // streaming data words into the selected memory
    ST_DONE = 2'd3   // single completion cycle, s_ready low
  } state_e;

  // Address width of memory type 'sel'. The vector is zero-extended to the
  // maximum number of types by the caller, so any 3-bit select is in range.
  function automatic logic [AW_FIELD_W-1:0] mem_aw(
    input logic [AW_VEC_W-1:0]  vec,
    input logic [HDR_MEM_W-1:0] sel
  );
    return vec[int'(sel)*AW_FIELD_W +: AW_FIELD_W];
  endfunction

endpackage

// File: rtl/qdrv_mem_loader_wdec.sv
// -----------------------------------------------------------------------------
// qdrv_mem_loader_wdec
//
// Purpose:
//   Registered one-hot write-enable decoder for the NUM_CORES x NUM_MEMS
//   array of RAM write ports. Bit index is core*NUM_MEMS + mem.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   core_sel_i   in   latched core select of the current burst
//   mem_sel_i    in   latched memory-type select of the current burst
//   bound_ok_i   in   current write address lies inside the memory depth
//   beat_valid_i in   an accepted data beat that is allowed to write
//   mem_wen_o    out  registered one-hot write enable (all zero when idle)
// -----------------------------------------------------------------------------
module qdrv_mem_loader_wdec
  import qdrv_mem_loader_pkg::*;
#(
  parameter int NUM_CORES = 3,
  parameter int NUM_MEMS  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [HDR_CORE_W-1:0]         core_sel_i,
  input  logic [HDR_MEM_W-1:0]          mem_sel_i,
  input  logic                          bound_ok_i,
  input  logic                          beat_valid_i,
  output logic [NUM_CORES*NUM_MEMS-1:0] mem_wen_o
);

  localparam int NUM_PORTS = NUM_CORES * NUM_MEMS;

  logic [NUM_PORTS-1:0] wen_d;
  logic [NUM_PORTS-1:0] wen_q;
  logic                 in_range;
  int                   idx;

  // The range check is repeated here so the decoder can never raise a bit
  // for a select that aliases onto another core's port.
  always_comb begin
    in_range = (int'(core_sel_i) < NUM_CORES) && (int'(mem_sel_i) < NUM_MEMS);
    idx      = int'(core_sel_i) * NUM_MEMS + int'(mem_sel_i);
    wen_d    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      wen_d[i] = beat_valid_i & bound_ok_i & in_range & (idx == i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wen_q <= '0;
    end else begin
      wen_q <= wen_d;
    end
  end

  assign mem_wen_o = wen_q;

endmodule

// File: rtl/qdrv_mem_loader.sv
// -----------------------------------------------------------------------------
// qdrv_mem_loader
//
// Purpose:
//   Framed burst loader for the per-core element memories. A burst is a
//   header word (base address, mem_sel, core_sel), a length word (N) and N
//   data words written to auto-incremented addresses of one memory. Select
//   and bound checking, framing checks, a done pulse and sticky error flags
//   are provided.
//
// Handshake:
//   A stream beat transfers on every rising edge where s_valid & s_ready.
//   s_ready is high in IDLE, LEN and DATA, low in the DONE cycle and while
//   reset is asserted. s_data/s_last may change freely when no beat transfers.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   s_data     in   stream word (header, length or data)
//   s_valid    in   stream word valid
//   s_ready    out  loader accepts the word
//   s_last     in   marks the final data word of the burst
//   mem_wdata  out  registered write data, common to all RAMs
//   mem_waddr  out  registered write address, common to all RAMs
//   mem_wen    out  registered one-hot write enable, bit core*NUM_MEMS+mem
//   busy       out  burst in progress (state != IDLE)
//   done       out  one-cycle pulse at burst completion
//   err_sel    out  sticky: core/mem select out of range
//   err_bound  out  sticky: write address beyond memory depth
//   err_frame  out  sticky: s_last disagrees with the length word
//   err_clr    in   clears all sticky errors (wins over a same-cycle set)
//   csum       out  (QDRV_MEM_LOADER_CHECKSUM_EN only) running sum of the
//                   data words of the current burst, modulo 2^DATA_WIDTH
//
// Configuration:
//   QDRV_MEM_LOADER_CHECKSUM_EN  adds the csum output and its accumulator.
// -----------------------------------------------------------------------------
module qdrv_mem_loader
  import qdrv_mem_loader_pkg::*;
#(
  parameter int                       NUM_CORES  = 3,
  parameter int                       NUM_MEMS   = 3,
  parameter int                       DATA_WIDTH = 32,
  parameter int                       ADDR_WIDTH = 16,
  parameter logic [5*NUM_MEMS-1:0]    MEM_AW_VEC = 15'h298C
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          s_last,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  output logic [ADDR_WIDTH-1:0]         mem_waddr,
  output logic [NUM_CORES*NUM_MEMS-1:0] mem_wen,
  output logic                          busy,
  output logic                          done,
  output logic                          err_sel,
  output logic                          err_bound,
  output logic                          err_frame,
  input  logic                          err_clr
`ifdef QDRV_MEM_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]         csum
`endif
);

  localparam logic [AW_VEC_W-1:0] AW_VEC_EXT = AW_VEC_W'(MEM_AW_VEC);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic [HDR_MEM_W-1:0]    mem_sel_q, mem_sel_d;
  logic [HDR_CORE_W-1:0]   core_sel_q, core_sel_d;
  logic                    sel_ok_q, sel_ok_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic                    err_sel_q, err_sel_d;
  logic                    err_bound_q, err_bound_d;
  logic                    err_frame_q, err_frame_d;

  // ---------------------------------------------------------------------------
  // Beat classification
  // ---------------------------------------------------------------------------
  logic                    beat;
  logic                    hdr_acc, len_acc, dat_acc;
  logic [HDR_MEM_W-1:0]    hdr_mem;
  logic [HDR_CORE_W-1:0]   hdr_core;
  logic                    hdr_sel_ok;
  logic [LEN_W-1:0]        len_n;
  logic                    is_final;
  logic [AW_FIELD_W-1:0]   cur_aw;
  logic                    bound_ok;

  assign s_ready = ~reset & (state_q != ST_DONE);
  assign beat    = s_valid & s_ready;
  assign hdr_acc = beat & (state_q == ST_IDLE);
  assign len_acc = beat & (state_q == ST_LEN);
  assign dat_acc = beat & (state_q == ST_DATA);

  assign hdr_mem    = s_data[HDR_MEM_LSB  +: HDR_MEM_W];
  assign hdr_core   = s_data[HDR_CORE_LSB +: HDR_CORE_W];
  assign hdr_sel_ok = (int'(hdr_core) < NUM_CORES) && (int'(hdr_mem) < NUM_MEMS);
  assign len_n      = s_data[LEN_LSB +: LEN_W];

  // remaining == 1 means the beat being accepted now is the last one.
  assign is_final = (rem_q == LEN_W'(1));

  // Depth of the selected memory is 2^cur_aw; the address is in bounds when
  // nothing is left after shifting out the in-range bits.
  assign cur_aw   = mem_aw(AW_VEC_EXT, mem_sel_q);
  assign bound_ok = ((64'(addr_q) >> cur_aw) == 64'd0);

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (beat) state_d = ST_LEN;
      ST_LEN:  if (beat) state_d = (len_n == '0) ? ST_DONE : ST_DATA;
      ST_DATA: if (beat && is_final) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_d      = addr_q;
    rem_d       = rem_q;
    mem_sel_d   = mem_sel_q;
    core_sel_d  = core_sel_q;
    sel_ok_d    = sel_ok_q;
    wdata_d     = wdata_q;
    waddr_d     = waddr_q;
    err_sel_d   = err_sel_q;
    err_bound_d = err_bound_q;
    err_frame_d = err_frame_q;

    if (hdr_acc) begin
      // The base goes straight into the address counter; nothing else needs it.
      addr_d     = ADDR_WIDTH'(s_data[HDR_BASE_LSB +: HDR_BASE_W]);
      mem_sel_d  = hdr_mem;
      core_sel_d = hdr_core;
      sel_ok_d   = hdr_sel_ok;
      if (!hdr_sel_ok) err_sel_d = 1'b1;
    end

    if (len_acc) begin
      rem_d = len_n;
    end

    if (dat_acc) begin
      wdata_d = s_data;
      waddr_d = addr_q;
      addr_d  = addr_q + ADDR_WIDTH'(1);
      rem_d   = rem_q - LEN_W'(1);
      // Bound errors are only meaningful for a valid select; a bad select is
      // already reported through err_sel.
      if (sel_ok_q && !bound_ok) err_bound_d = 1'b1;
      if (s_last != is_final)    err_frame_d = 1'b1;
    end

    if (err_clr) begin
      err_sel_d   = 1'b0;
      err_bound_d = 1'b0;
      err_frame_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      mem_sel_q   <= '0;
      core_sel_q  <= '0;
      sel_ok_q    <= 1'b0;
      wdata_q     <= '0;
      waddr_q     <= '0;
      err_sel_q   <= 1'b0;
      err_bound_q <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      mem_sel_q   <= mem_sel_d;
      core_sel_q  <= core_sel_d;
      sel_ok_q    <= sel_ok_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
      err_sel_q   <= err_sel_d;
      err_bound_q <= err_bound_d;
      err_frame_q <= err_frame_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Write-enable decode (registered, aligned with mem_wdata/mem_waddr)
  // ---------------------------------------------------------------------------
  qdrv_mem_loader_wdec #(
    .NUM_CORES (NUM_CORES),
    .NUM_MEMS  (NUM_MEMS)
  ) u_wdec (
    .clk          (clk),
    .reset        (reset),
    .core_sel_i   (core_sel_q),
    .mem_sel_i    (mem_sel_q),
    .bound_ok_i   (bound_ok),
    .beat_valid_i (dat_acc & sel_ok_q),
    .mem_wen_o    (mem_wen)
  );

`ifdef QDRV_MEM_LOADER_CHECKSUM_EN
  // Sum covers every accepted data word, including suppressed writes, and is
  // left untouched from the done pulse until the next header clears it.
  logic [DATA_WIDTH-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (hdr_acc)      csum_d = '0;
    else if (dat_acc) csum_d = csum_q + s_data;
  end

  always_ff @(posedge clk) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign csum = csum_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_wdata = wdata_q;
  assign mem_waddr = waddr_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err_sel   = err_sel_q;
  assign err_bound = err_bound_q;
  assign err_frame = err_frame_q;

endmodule

// File: doc/qdrv_mem_loader.md
Name: qdrv_mem_loader

Overview:
Parametrised burst loader for the per-core element memories (command, envelope, frequency, and further types) that feed the dsp core array. It replaces the flat per-word write decode (proc/mem select plus address on every word) with a framed stream: a header word, a length word, then N data words written to auto-incremented addresses. Bounds and select checking, completion signalling and error flags are included. The block sits between the host/cocotb write bus and a NUM_CORES × NUM_MEMS array of aligned_ram write ports.

Parameters:
NUM_CORES, 3, number of processor cores; 1..16
NUM_MEMS, 3, memory types per core (0 cmd, 1 env, 2 freq, ...); 1..8
DATA_WIDTH, 32, stream and RAM write-data width
ADDR_WIDTH, 16, width of the shared write-address output
MEM_AW_VEC, 15'h298C, packed 5-bit write-address widths, one per memory type, mem0 at LSBs; default gives cmd 12, env 12, freq 10

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
s_data  in  DATA_WIDTH  stream word (header, length or data)
s_valid  in  1  stream word valid
s_ready  out  1  loader accepts word; a beat is transferred when s_valid & s_ready
s_last  in  1  marks final data word of burst
mem_wdata  out  DATA_WIDTH  registered write data to all RAMs
mem_waddr  out  ADDR_WIDTH  registered write address
mem_wen  out  NUM_CORES*NUM_MEMS  one-hot write enable; bit index core*NUM_MEMS+mem
busy  out  1  burst in progress (state != IDLE)
done  out  1  one-cycle pulse at burst completion
err_sel  out  1  sticky: core/mem select out of range
err_bound  out  1  sticky: write address beyond memory depth
err_frame  out  1  sticky: s_last disagrees with length
err_clr  in  1  clears all sticky errors

Behaviour:
- Reset values: s_ready=0, mem_wen=0, mem_wdata=0, mem_waddr=0, busy=0, done=0, all err_*=0. The FSM enters IDLE.
- s_ready is 1 in IDLE, LEN and DATA states. It is 0 during reset and in the single DONE cycle.
- Header word format: [15:0] base address, [18:16] mem_sel, [22:19] core_sel, [31:23] reserved (ignored).
- Length word format: [15:0] count N of data words.
- FSM:
  - IDLE: accepted beat → latch header → LEN.
  - LEN: accepted beat → latch N. If N=0 → DONE; else → DATA with addr=base, remaining=N.
  - DATA: each accepted beat writes, then addr += 1 and remaining -= 1. When remaining reaches 0 after a beat → DONE.
  - DONE: done=1 for 1 cycle, then → IDLE.
- Write latency: mem_wen, mem_waddr and mem_wdata are registered 1 cycle after the accepted data beat. mem_wen is 0 in every cycle without an accepted data beat.
- Address counter: ADDR_WIDTH wide and wraps modulo 2^ADDR_WIDTH.
- Bound check: compare against 2^MEM_AW[mem_sel]. If addr ≥ depth, suppress mem_wen for that beat and set err_bound; the burst continues.
- Select check: if core_sel ≥ NUM_CORES or mem_sel ≥ NUM_MEMS, set err_sel at header accept. All N data beats are consumed with no writes.
- Framing:
  - s_last=1 on a beat that is not the final one → err_frame; the burst still runs to N.
  - s_last=0 on the final beat → err_frame.
  - s_last is ignored in IDLE and LEN.
- err_clr: has priority over a same-cycle error set (clear wins). Errors are sticky otherwise.
- Reset mid-burst: the FSM returns to IDLE and mem_wen=0 in the cycle after reset is sampled. The partial burst is abandoned and no done pulse is generated.
- Back-to-back bursts: a header may be presented in the cycle after DONE (IDLE). There is no other bubble.

Optional Feature:
QDRV_MEM_LOADER_CHECKSUM_EN:
- Defined:
  - Adds output csum [DATA_WIDTH-1:0]: running modulo-2^DATA_WIDTH sum of all data words accepted in the current burst.
  - Cleared when the header is accepted.
  - Holds its final value from the done pulse until the next header.
  - Suppressed writes are still summed.
- Undefined: port and logic absent.

Decomposition:
- Package qdrv_mem_loader_pkg holds:
  - the header field positions and widths (BASE, MEM_SEL, CORE_SEL);
  - the FSM state enum {IDLE, LEN, DATA, DONE};
  - a function returning the MEM_AW_VEC slice for a given mem_sel.
- One natural sub-module: qdrv_mem_loader_wdec. It takes core_sel, mem_sel, bound-ok and beat-valid and produces the registered one-hot mem_wen.

Test Plan:
- Header core=1 mem=2 base=0x0010, N=3, data A,B,C with s_last on C → mem_wen bit 5 high for 3 cycles, addresses 0x10/0x11/0x12 with A/B/C, one done pulse, no errors.
- Header core=0 mem=0, N=0 → no writes, done one cycle after the length beat, s_ready low for that cycle.
- Header core=3 (NUM_CORES=3), N=2 → err_sel=1, two beats consumed, mem_wen stays 0, done pulses. Then err_clr → err_sel=0.
- freq mem (depth 1024), base=0x03FF, N=2 → first write at 0x3FF, second suppressed, err_bound=1.
- N=4 with s_last on beat 2 → err_frame=1, all 4 writes occur. Assert reset after beat 2 of a second burst → mem_wen=0 next cycle, busy=0, no done.
- With checksum enabled: data 0xFFFFFFFF, 0x00000002 → csum=0x00000001 at done.
